// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types and width helpers for the 2-way data cache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } dcache_state_t;

  // Index bits selecting a set.
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: byte address minus word offset and index.
  function automatic int tag_bits(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// ============================================================================
// Module   : dcache_way
// Brief    : One cache way: valid/tag/data arrays, combinational lookup and a
//            synchronous fill/write/invalidate port.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_way
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int IB         = idx_bits(SETS),
  parameter int TW         = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IB-1:0]         lk_idx_i,
  input  logic [TW-1:0]         lk_tag_i,
  output logic                  hit_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  wr_en_i,
  input  logic                  inv_i,
  input  logic [IB-1:0]         wr_idx_i,
  input  logic [TW-1:0]         wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [SETS-1:0]       valid_q;
  logic [TW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  assign valid_o = valid_q[lk_idx_i];
  assign hit_o   = valid_o && (tag_q[lk_idx_i] == lk_tag_i);
  assign data_o  = data_q[lk_idx_i];

  // Valid bits: cleared on reset, set by a fill/write, cleared by invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end else if (inv_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end
  end

  // Tag/data storage; contents are qualified by the valid bit so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_2way.sv
`default_nettype none
// ============================================================================
// Module   : dcache_2way
// Brief    : Memory-stage 2-way set-associative write-through,
//            no-write-allocate data cache with 1-bit LRU per set and a
//            req/ack handshake to main memory.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReadEnM,
  input  logic                  MemWriteM,
  input  logic                  cache_WEM,
  input  logic [ADDR_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int IB = idx_bits(SETS);
  localparam int TW = tag_bits(ADDR_WIDTH, SETS);
  localparam int WW = ADDR_WIDTH - 2;

  dcache_state_t         state_q, state_d;
  logic [WW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  shit_q, shit_d;   // captured store was a hit
  logic                  sway_q, sway_d;   // way the store hit
  logic                  wem_q, wem_d;     // captured cache_WEM
  logic [SETS-1:0]       lru_q;

  logic                  lru_we, lru_val;
  logic [1:0]            fill_we, inv;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [WW-1:0]         lk_word;
  logic [IB-1:0]         lk_idx;
  logic [TW-1:0]         lk_tag;
  logic [1:0]            way_hit, way_valid;
  logic [DATA_WIDTH-1:0] way_data [2];
  logic                  hit, hway, victim, access;
  logic                  unused_addr_lsb;

  // The byte offset is not part of a word access.
  assign unused_addr_lsb = ^AddrM[1:0];

  // While waiting, look up the captured address so fills target the right set.
  assign lk_word = (state_q == IDLE) ? AddrM[ADDR_WIDTH-1:2] : addr_q;
  assign lk_idx  = lk_word[IB-1:0];
  assign lk_tag  = lk_word[WW-1:IB];

  assign hit    = |way_hit;
  assign hway   = way_hit[1];
  assign victim = !way_valid[0] ? 1'b0 :
                  !way_valid[1] ? 1'b1 : lru_q[lk_idx];
  assign access = ReadEnM | MemWriteM;

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == WR_WAIT);
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .SETS       (SETS),
      .IB         (IB),
      .TW         (TW)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .lk_idx_i  (lk_idx),
      .lk_tag_i  (lk_tag),
      .hit_o     (way_hit[w]),
      .valid_o   (way_valid[w]),
      .data_o    (way_data[w]),
      .wr_en_i   (fill_we[w]),
      .inv_i     (inv[w]),
      .wr_idx_i  (lk_idx),
      .wr_tag_i  (lk_tag),
      .wr_data_i (wr_data)
    );
  end

  // Next-state, array-update and pipeline-facing output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shit_d    = shit_q;
    sway_d    = sway_q;
    wem_d     = wem_q;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    fill_we   = 2'b00;
    inv       = 2'b00;
    wr_data   = wdata_q;
    StallM    = access;
    ReadDataM = '0;
    case (state_q)
      IDLE: begin
        if (MemWriteM) begin
          addr_d  = AddrM[ADDR_WIDTH-1:2];
          wdata_d = WriteDataM;
          shit_d  = hit;
          sway_d  = hway;
          wem_d   = cache_WEM;
          state_d = WR_WAIT;
        end else if (ReadEnM) begin
          if (hit) begin
            StallM    = 1'b0;
            ReadDataM = way_data[hway];
            lru_we    = 1'b1;
            lru_val   = ~hway;
          end else begin
            addr_d  = AddrM[ADDR_WIDTH-1:2];
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          fill_we[victim] = 1'b1;
          wr_data         = mem_rdata;
          lru_we          = 1'b1;
          lru_val         = ~victim;
          state_d         = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          StallM = 1'b0;
          if (shit_q) begin
            if (wem_q) begin
              fill_we[sway_q] = 1'b1;
              lru_we          = 1'b1;
              lru_val         = ~sway_q;
            end else begin
              inv[sway_q] = 1'b1;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request fields and LRU bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      shit_q  <= 1'b0;
      sway_q  <= 1'b0;
      wem_q   <= 1'b0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shit_q  <= shit_d;
      sway_q  <= sway_d;
      wem_q   <= wem_d;
      if (lru_we) lru_q[lk_idx] <= lru_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_2way
// Brief    : Self-checking bench for dcache_2way with a load-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ReadEnM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        cache_WEM = 1'b0;
  logic [31:0] AddrM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  dcache_2way #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ReadEnM    (ReadEnM),
    .MemWriteM  (MemWriteM),
    .cache_WEM  (cache_WEM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted load pops one expected word.
  always @(negedge clk) begin
    if (!rst && ReadEnM && !MemWriteM && !StallM) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL load_data: got %h with nothing expected", ReadDataM);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ReadDataM !== e) begin
          bad++;
          $display("FAIL load_data: got %h want %h", ReadDataM, e);
        end
      end
    end
  end

  // Runs one held access until the pipeline is released; acks the lat-th request cycle.
  task automatic run_access(input int lat, input logic [31:0] rd, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int stalls, output int reqs);
    stalls = 0;
    reqs   = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mem_req) begin
        total++;
        if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== wd)) begin
          bad++;
          $display("FAIL req_fields: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, we, a, wd);
        end
      end
      if (!StallM) return;
      stalls++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        reqs++;
        if (reqs == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    total++;
    bad++;
    $display("FAIL timeout: got stall after 64 cycles want release");
  endtask

  task automatic do_load(input string nm, input logic [31:0] a, input int lat,
                         input logic [31:0] rd, input logic [31:0] exp,
                         input int exp_stalls, input int exp_reqs);
    int s, r;
    @(posedge clk); #1;
    ReadEnM = 1'b1; MemWriteM = 1'b0; AddrM = a;
    exp_q.push_back(exp);
    run_access(lat, rd, 1'b0, a, 32'h0, s, r);
    @(posedge clk); #1;
    ReadEnM = 1'b0; mem_ack = 1'b0;
    chk({nm, "_stall"}, s, exp_stalls);
    chk({nm, "_reqs"}, r, exp_reqs);
  endtask

  task automatic do_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic wem, input logic rd_too, input int lat);
    int s, r;
    @(posedge clk); #1;
    ReadEnM = rd_too; MemWriteM = 1'b1; cache_WEM = wem; AddrM = a; WriteDataM = d;
    run_access(lat, 32'h0, 1'b1, a, d, s, r);
    @(posedge clk); #1;
    ReadEnM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
    chk({nm, "_stall"}, s, lat);
    chk({nm, "_reqs"}, r, lat);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, StallM}, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_req", {30'b0, mem_req, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);

    // Cold miss then hit
    do_load("cold_miss", 32'h40, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4, 3);
    do_load("rehit", 32'h40, 1, 32'h0, 32'hDEADBEEF, 0, 0);

    // LRU eviction in set 0
    do_load("fill_w1", 32'h140, 1, 32'h11111111, 32'h11111111, 2, 1);
    do_load("hit_40a", 32'h40, 1, 32'h0, 32'hDEADBEEF, 0, 0);
    do_load("evict", 32'h240, 2, 32'h22222222, 32'h22222222, 3, 2);
    do_load("hit_40b", 32'h40, 1, 32'h0, 32'hDEADBEEF, 0, 0);
    do_load("miss_140", 32'h140, 1, 32'h33333333, 32'h33333333, 2, 1);

    // Store hit with update
    do_store("st_hit", 32'h40, 32'h12345678, 1'b1, 1'b0, 2);
    do_load("ld_upd", 32'h40, 1, 32'h0, 32'h12345678, 0, 0);

    // Store miss (load also asserted: store wins)
    do_store("st_miss", 32'h80, 32'hCAFEF00D, 1'b1, 1'b1, 1);
    do_load("ld_80", 32'h80, 1, 32'h44444444, 32'h44444444, 2, 1);

    // Store hit with invalidate
    do_store("st_inv", 32'h40, 32'h55555555, 1'b0, 1'b0, 1);
    do_load("ld_inv", 32'h40, 2, 32'h66666666, 32'h66666666, 3, 2);
    do_load("hit_inv", 32'h40, 1, 32'h0, 32'h66666666, 0, 0);

    // Reset during RD_WAIT
    @(posedge clk); #1;
    ReadEnM = 1'b1; AddrM = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", {31'b0, mem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_req", {31'b0, mem_req}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_stall", {31'b0, StallM}, 32'h1);
    ReadEnM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_load("post_rst", 32'h40, 2, 32'h77777777, 32'h77777777, 3, 2);

    repeat (2) @(posedge clk);
    chk("sb_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
